// File: rtl/sensor_poll_if.sv
// Signal bundle between the sensor scanner and its environment.
// The master side drives the enable level and the shared sensor return line.
// The slave side (the scanner) drives the select lines and the results.
interface sensor_poll_if;
  logic       enable;
  logic       sense_in;
  logic [3:0] sel;
  logic [3:0] sensors;
  logic       fault;
  logic       scan_done;

  modport master (
    output enable,
    output sense_in,
    input  sel,
    input  sensors,
    input  fault,
    input  scan_done
  );

  modport slave (
    input  enable,
    input  sense_in,
    output sel,
    output sensors,
    output fault,
    output scan_done
  );
endinterface

// File: rtl/sensor_poll.sv
// Four-sensor scanning front end.
// The block walks a one-hot select across four sensors that share one return
// line. It waits a settle time for each sensor and then samples it once.
// After each full scan it commits a two-scan debounced vector, a fault flag
// derived from that vector, and a one-cycle scan_done strobe.
module sensor_poll #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  sensor_poll_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Fault rule: sensor 0 alone, or sensor 1 together with sensor 2 or 3.
  function automatic logic fault_rule(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

  // A bit follows the new sample only when two consecutive scans agree;
  // otherwise the previously published value is held.
  function automatic logic [3:0] debounce(input logic [3:0] cur,
                                          input logic [3:0] prev,
                                          input logic [3:0] held);
    logic [3:0] agree;
    agree = ~(cur ^ prev);
    return (cur & agree) | (held & ~agree);
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    sel_r, sel_s;
  logic [3:0]    cur_r, cur_s;
  logic [3:0]    prev_r, prev_s;
  logic [3:0]    sensors_r, sensors_s;
  logic          fault_r, fault_s;
  logic          done_r, done_s;

  // State and datapath registers; outputs clear immediately on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      cnt_r     <= CNT_ZERO;
      sel_r     <= 4'b0000;
      cur_r     <= 4'b0000;
      prev_r    <= 4'b0000;
      sensors_r <= 4'b0000;
      fault_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      sel_r     <= sel_s;
      cur_r     <= cur_s;
      prev_r    <= prev_s;
      sensors_r <= sensors_s;
      fault_r   <= fault_s;
      done_r    <= done_s;
    end
  end

  // Next-state logic; sel and scan_done are computed one cycle early so
  // that their registered copies line up with the state they belong to.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    sel_s     = sel_r;
    cur_s     = cur_r;
    prev_s    = prev_r;
    sensors_s = sensors_r;
    fault_s   = fault_r;
    done_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.enable) begin
          state_s = SETTLE;
          idx_s   = 2'd0;
          cnt_s   = CNT_ZERO;
          sel_s   = 4'b0001;
        end else begin
          state_s = IDLE;
          sel_s   = 4'b0000;
        end
      end

      SETTLE: begin
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = SAMPLE;
        end else begin
          state_s = SETTLE;
        end
      end

      SAMPLE: begin
        cur_s[idx_r] = bus.sense_in;
        if (idx_r == 2'd3) begin
          state_s = DONE;
          sel_s   = 4'b0000;
          done_s  = 1'b1;
        end else begin
          state_s = SETTLE;
          idx_s   = idx_r + 2'd1;
          cnt_s   = CNT_ZERO;
          sel_s   = {sel_r[2:0], 1'b0};
        end
      end

      DONE: begin
        sensors_s = debounce(cur_r, prev_r, sensors_r);
        prev_s    = cur_r;
        fault_s   = fault_rule(sensors_s);
        idx_s     = 2'd0;
        cnt_s     = CNT_ZERO;
        if (bus.enable) begin
          state_s = SETTLE;
          sel_s   = 4'b0001;
        end else begin
          state_s = IDLE;
          sel_s   = 4'b0000;
        end
      end

      default: begin
        state_s = IDLE;
        sel_s   = 4'b0000;
      end
    endcase
  end

  assign bus.sel       = sel_r;
  assign bus.sensors   = sensors_r;
  assign bus.fault     = fault_r;
  assign bus.scan_done = done_r;

endmodule

// File: tb/tb_sensor_poll.sv
// Bench for sensor_poll with SETTLE_CYCLES = 4.
// The stimulus pushes the expected {sensors, fault} for every scan into a
// queue. A monitor pops one entry for each scan_done and compares it with the
// outputs one cycle later. Sequencing and reset checks are done inline.
module tb_sensor_poll;

  logic clk = 1'b0;
  logic n_rst;
  sensor_poll_if bus();

  sensor_poll #(.SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sensors;
    logic       fault;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] pat   = 4'b0000;
  int         mode  = 0;       // 0: pattern, 1: toggle in settle, 2: constant 1
  logic [3:0] last_sel = 4'b0000;
  int         phase = 0;
  logic       tog   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic f);
    exp_t e;
    e.sensors = s;
    e.fault   = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.scan_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no scan_done within 100 cycles, expected a pulse", name);
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.sel === s) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: sel never reached %b within 100 cycles", name, s);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Sensor return driver: phase counts cycles since sel last changed, so
  // phase 4 is the SAMPLE cycle of each sensor.
  initial begin
    bus.sense_in = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sel !== last_sel) phase = 0;
      else if (phase < 15) phase++;
      last_sel = bus.sel;
      tog = ~tog;
      case (mode)
        0:       bus.sense_in = |(bus.sel & pat);
        1:       bus.sense_in = (phase == 4) ? 1'b1 : tog;
        2:       bus.sense_in = 1'b1;
        default: bus.sense_in = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: results are stable the cycle after scan_done.
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && bus.scan_done === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_scan_done: got a pulse at %0t, expected none", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_sensors", bus.sensors, mon_e.sensors);
          check("sb_fault", bus.fault, mon_e.fault);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    logic [3:0] one;
    one = 4'b0001;
    n_rst = 1'b0;
    bus.enable = 1'b0;
    #3;
    check("rst_sel", bus.sel, 4'b0000);
    check("rst_sensors", bus.sensors, 4'b0000);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_done", bus.scan_done, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_sel", bus.sel, 4'b0000);
    end

    // Stuck-high input: sequencing, first and second scan results.
    mode = 2;
    push(4'b0000, 1'b0);
    push(4'b1111, 1'b1);
    bus.enable = 1'b1;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 20) begin
        check("seq_sel", bus.sel, (k < 20) ? (one << (k / 5)) : 4'b0000);
        check("seq_done", bus.scan_done, (k == 20) ? 1'b1 : 1'b0);
      end else begin
        check("seq_done2", bus.scan_done, (k == 41) ? 1'b1 : 1'b0);
      end
    end
    wait_drain("drain_stuck");

    // Asynchronous reset in SETTLE of sensor 2.
    wait_sel(4'b0100, "reach_idx2");
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_sel", bus.sel, 4'b0000);
    check("arst_sensors", bus.sensors, 4'b0000);
    check("arst_fault", bus.fault, 1'b0);
    check("arst_done", bus.scan_done, 1'b0);
    bus.enable = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("post_rst_sel", bus.sel, 4'b0000);
      check("post_rst_done", bus.scan_done, 1'b0);
    end

    // Pattern response.
    mode = 0;
    pat  = 4'b0110;
    push(4'b0000, 1'b0);
    push(4'b0110, 1'b1);
    bus.enable = 1'b1;
    wait_done("p0110_a");
    wait_done("p0110_b");
    pat = 4'b1000;
    push(4'b0110, 1'b1);
    push(4'b1000, 1'b0);
    wait_done("p1000_a");
    wait_done("p1000_b");

    // Back to all-zero, then a one-scan glitch on sensor 0.
    pat = 4'b0000;
    push(4'b1000, 1'b0);
    push(4'b0000, 1'b0);
    wait_done("p0000_a");
    wait_done("p0000_b");
    pat = 4'b0001;
    push(4'b0000, 1'b0);
    wait_done("glitch");
    pat = 4'b0000;
    push(4'b0000, 1'b0);
    push(4'b0000, 1'b0);
    wait_done("post_glitch_a");
    wait_done("post_glitch_b");

    // Toggling during settle, 1 only in SAMPLE.
    mode = 1;
    push(4'b0000, 1'b0);
    push(4'b1111, 1'b1);
    wait_done("toggle_a");
    wait_done("toggle_b");

    // Enable drop during sensor 1: scan completes and commits.
    mode = 0;
    pat  = 4'b0000;
    push(4'b1111, 1'b1);
    wait_done("pre_drop");
    push(4'b0000, 1'b0);
    wait_sel(4'b0010, "reach_idx1");
    bus.enable = 1'b0;
    wait_done("drop_scan");
    @(negedge clk);
    check("drop_idle_sel", bus.sel, 4'b0000);
    repeat (50) begin
      @(negedge clk);
      check("drop_idle_sel2", bus.sel, 4'b0000);
      check("drop_no_done", bus.scan_done, 1'b0);
    end
    wait_drain("drain_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_poll.md
# sensor_poll

Scanning front end that produces the 4-bit `sensors` vector consumed by the sensor error logic. It drives one-hot selects to four sensors that share a single `sense_in` return line. For each sensor it waits a settle time, samples once, and debounces across two consecutive scans. At the end of each scan it publishes the debounced vector, a registered fault flag and a one-cycle `scan_done` strobe.

## Interface
- `SETTLE_CYCLES`, default 4: cycles spent in SETTLE per sensor before sampling; legal range is 1 and up.
- `clk`  in  1  system clock; all flops update on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; start scanning and keep scanning while high.
- `sense_in`  in  1  shared sensor return, valid only for the currently selected sensor.
- `sel`  out  4  one-hot sensor select; bit i selects sensor i; 4'b0000 when idle.
- `sensors`  out  4  debounced sensor vector, registered.
- `fault`  out  1  registered: `sensors[0] | (sensors[1] & (sensors[2] | sensors[3]))`, computed from the newly committed vector.
- `scan_done`  out  1  one-cycle pulse in the DONE state.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `sel` = 0.
  - If `enable` = 1, go to SETTLE with idx = 0, `sel` = 4'b0001, settle count = 0.
- SETTLE:
  - `sel` = one-hot(idx).
  - Settle count increments each cycle.
  - After SETTLE_CYCLES cycles in this state, go to SAMPLE.
  - `sense_in` is ignored here.
- SAMPLE (1 cycle):
  - `sel` is held.
  - cur[idx] <= `sense_in`.
  - If idx = 3, go to DONE. Otherwise idx++, `sel` shifts left, settle count = 0, go to SETTLE.
- DONE (1 cycle):
  - `sel` = 0, `scan_done` = 1.
  - For each bit i: if cur[i] == prev[i], then `sensors[i]` <= cur[i]; otherwise `sensors[i]` holds.
  - prev <= cur.
  - `fault` <= rule applied to the new `sensors` value.
  - If `enable` = 1, go to SETTLE with idx = 0 and `sel` = 4'b0001 (no IDLE gap). Otherwise go to IDLE.
- Debounce: a sensor bit changes only after two consecutive scans sample the same new value. A single-scan glitch never reaches `sensors`.
- `enable` falling mid-scan: the current scan completes, including DONE and its commit, then the block goes to IDLE. `enable` is sampled only in IDLE and DONE.
- Settle counter width: clog2(SETTLE_CYCLES+1). No wrap-around occurs within a state.
- `sel` is always either one-hot or zero, never multi-hot.

## Timing
- Reset (async, `n_rst` = 0): state = IDLE, `sel` = 0, `sensors` = 0, `fault` = 0, `scan_done` = 0, cur = 0, prev = 0, idx = 0, settle count = 0. Outputs go low immediately, without waiting for a clock.
- Reset release mid-scan: the block resumes from IDLE; no partial commit takes place.
- Edge E0 samples `enable` = 1 in IDLE; `sel` = 4'b0001 after E0.
- Per sensor: SETTLE_CYCLES + 1 cycles.
- Scan: 4·(SETTLE_CYCLES+1) cycles, then 1 DONE cycle. With the default, `scan_done` is high in the cycle after edge E0+20.
- Back-to-back scans: DONE to DONE period is 4·(SETTLE_CYCLES+1)+1 = 21 cycles with the default.
- `sensors` and `fault` change at the same edge that ends DONE, so they are stable one cycle after the `scan_done` pulse. They hold until the next DONE.
- After reset (prev = 0), a sensor stuck at 1 appears on `sensors` at the end of the second scan.

## Test plan
All scenarios use SETTLE_CYCLES = 4.
1. **Reset:** assert `n_rst` = 0 asynchronously mid-cycle while in SETTLE with idx = 2. Required: `sel` = 0, `sensors` = 0, `fault` = 0, `scan_done` = 0 before the next clock edge. After release, the block stays in IDLE while `enable` = 0.
2. **Stuck-high and scan sequencing:** hold `enable` = 1 and `sense_in` = 1.
   - `sel` steps 0001 → 0010 → 0100 → 1000, 5 cycles each.
   - First `scan_done` after 21 cycles with `sensors` = 0000.
   - Second `scan_done` 21 cycles later; then `sensors` = 1111 and `fault` = 1.
3. **Pattern response:** drive `sense_in` = |(`sel` & P).
   - P = 4'b0110 for two scans → `sensors` = 0110, `fault` = 1.
   - Then P = 4'b1000 for two scans → `sensors` = 1000, `fault` = 0.
4. **Glitch rejection:** from `sensors` = 0000, use P = 4'b0001 for exactly one scan, then P = 0000. Required: `sensors` stays 0000 and `fault` stays 0 for all `scan_done` pulses.
5. **Settle window ignored:** toggle `sense_in` every cycle during SETTLE, holding 1 only in SAMPLE cycles, for two scans. Required: `sensors` = 1111.
6. **Enable drop mid-scan:** deassert `enable` while idx = 1. Required: the scan completes, `scan_done` pulses once, the commit happens, then `sel` = 0 in IDLE and no further `scan_done` occurs.
